lfsr_prng: RTL and testbench
============================

# lfsr_prng

Parametrised pseudo-random generator: a WIDTH-bit LFSR in Fibonacci or Galois form with seed loading, zero-state lock-up protection and a valid/ready output stream. It adds a period monitor that reports the measured sequence length each time the state returns to its seed. It feeds test-pattern, scrambler and dither consumers in the register/sequential exercise set.

## Interface
- WIDTH, 8: state width, legal range 3..32
- MODE, 0: 0 = Fibonacci (shift right, feedback into MSB), 1 = Galois (shift right, conditional XOR mask)
- TAPS, 'h1D: Fibonacci tap mask; feedback = XOR of state bits whose TAPS bit is 1 (default bits 4,3,2,0)
- GMASK, 'hB8: Galois mask XORed into the shifted state when the outgoing LSB is 1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- en  in  1  run request; generator produces words while high
- seed_load  in  1  one-cycle pulse: load seed_in
- seed_in  in  WIDTH  seed value
- out_data  out  WIDTH  current state
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- period_done  out  1  one-cycle pulse: state returned to seed
- period_len  out  WIDTH  advances counted in the last completed period

## Operation
- Reset (reset = 0): state = 1, seed_reg = 1, out_valid = 0, period_done = 0, period_len = 0, count = 0.
- Advance occurs on out_valid && out_ready.
  - Fibonacci: next = {^(state & TAPS), state[WIDTH-1:1]}.
  - Galois: next = (state >> 1) ^ (state[0] ? GMASK : 0).
- Zero protection: a seed_in of 0 loads 1. Any computed next state of 0 is replaced by 1.
- seed_load has priority over advance and over the hold rule.
  - It writes state and seed_reg and clears count.
  - out_valid is forced to 0 in the load cycle.
- out_valid is a register. It follows en with one cycle latency.
- Once out_valid = 1 and out_ready = 0:
  - out_data and out_valid hold.
  - Deasserting en takes effect only after the handshake completes. The one exception is seed_load.
- Period monitor:
  - Each advance increments count.
  - If the next state equals seed_reg, period_len <= count + 1, count <= 0, and period_done pulses in the following cycle.
  - count never exceeds 2^WIDTH - 2.
- TAPS and GMASK are truncated to WIDTH bits. Bits above WIDTH are ignored.

## Timing
- en rises at edge N -> out_valid = 1 after edge N+1. out_data is the current state, with no pipeline delay.
- Handshake at edge N -> new out_data visible after edge N.
- Back-to-back: one word per cycle while out_ready = 1.
- seed_load at edge N -> out_data = seed (or 1) after N. out_valid reappears after N+1 if en = 1.
- period_done: high for exactly one cycle, after the edge of the advance that reached the seed. period_len updates on that same edge.
- seed_load and advance in the same cycle: the load wins, no advance is counted, and period_done is not raised.
- Asynchronous reset mid-stream: all outputs return to their reset values immediately. No partial handshake is remembered.

## Structure
- Shared package lfsr_pkg:
  - mode constants LFSR_FIB = 0, LFSR_GAL = 1
  - default maximal-length mask constants for widths 3..32, both forms
  - function lfsr_next(state, mode, taps, gmask) used by RTL and the reference model
- Sub-module lfsr_period_mon holds seed_reg, count, period_len and period_done. The top keeps the state register and the handshake.

## Test plan
- Reset value check: reset low, then high with en = 0 -> out_data = 0x01, out_valid = 0, period_done = 0, period_len = 0.
- Fibonacci sequence: WIDTH 8, defaults, en = 1, out_ready = 1 -> accepted words 0x01, 0x80, 0x40, 0x20, 0x10, 0x88.
  - After 255 advances: period_done pulses once and period_len = 255.
- Galois period: MODE 1, GMASK 'hB8 -> no repeated state within 255 advances; period_len = 255. Compare against lfsr_next.
- Backpressure: out_ready low for 5 cycles mid-stream -> out_data and out_valid stable.
  - Drop en during the stall -> one more word is delivered on the handshake, then out_valid = 0.
- Seed load: seed_in = 0x00 -> out_data = 0x01.
  - seed_in = 0x5A concurrent with a handshake -> out_data = 0x5A, out_valid = 0 for one cycle, count = 0.
  - Return to 0x5A -> period_len = 255.
- Reset mid-stream: assert reset during a stall -> outputs at reset values immediately.
  - Release -> sequence restarts at 0x01.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - mode constants, maximal-length masks and the shared LFSR step function
package lfsr_pkg;

  localparam int unsigned LFSR_FIB = 0;
  localparam int unsigned LFSR_GAL = 1;

  // Right-shift Galois masks for maximal-length sequences, indexed by width.
  localparam logic [31:0] LFSR_GAL_MASKS [3:32] = '{
    32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
    32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
    32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
    32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
    32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
    32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
    32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
    32'h4800_0000, 32'h8020_0003
  };

  function automatic logic [31:0] lfsr_default_gmask(input int width);
    return LFSR_GAL_MASKS[width];
  endfunction

  // Fibonacci taps use the reciprocal polynomial of the Galois mask.
  function automatic logic [31:0] lfsr_default_taps(input int width);
    logic [31:0] g;
    logic [31:0] f;
    g = LFSR_GAL_MASKS[width];
    f = 32'd1;
    for (int i = 0; i < width - 1; i++) begin
      if (g[i]) f[width-1-i] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic mode,
                                            input logic [31:0] taps, input logic [31:0] gmask,
                                            input int width);
    logic [31:0] wmask;
    logic [31:0] s;
    logic [31:0] n;
    wmask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    s = state & wmask;
    if (mode) begin
      n = (s >> 1) ^ (s[0] ? (gmask & wmask) : 32'd0);
    end else begin
      n = (s >> 1) | (32'(^(s & taps & wmask)) << (width - 1));
    end
    n = n & wmask;
    if (n == 32'd0) n = 32'd1;
    return n;
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// rtl/lfsr_period_mon.sv - seed register and sequence-length monitor
module lfsr_period_mon
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  input  logic             advance,
  input  logic [WIDTH-1:0] next_state,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len
);

  localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             done_q, done_d;

  always_comb begin
    seed_d  = seed_q;
    count_d = count_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (seed_load) begin
      seed_d  = seed_val;
      count_d = '0;
    end else if (advance) begin
      if (next_state == seed_q) begin
        len_d   = count_q + WIDTH'(1);
        count_d = '0;
        done_d  = 1'b1;
      end else if (count_q != CNT_MAX) begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q  <= WIDTH'(1);
      count_q <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      seed_q  <= seed_d;
      count_q <= count_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign period_done = done_q;
  assign period_len  = len_q;

endmodule

// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - Fibonacci/Galois LFSR with seed load and valid/ready output stream
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = LFSR_FIB,
  parameter logic [31:0] TAPS  = 32'h1D,
  parameter logic [31:0] GMASK = 32'hB8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_fix;
  logic             advance;

  assign advance    = valid_q & out_ready & ~seed_load;
  assign next_state = WIDTH'(lfsr_next(32'(state_q), MODE == LFSR_GAL, TAPS, GMASK, int'(WIDTH)));
  assign seed_fix   = (seed_in == '0) ? WIDTH'(1) : seed_in;

  // A pending word is never withdrawn: en is only re-sampled once the stream is free.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (seed_load) begin
      state_d = seed_fix;
      valid_d = 1'b0;
    end else begin
      if (advance) state_d = next_state;
      if (!valid_q || out_ready) valid_d = en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WIDTH'(1);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = state_q;
  assign out_valid = valid_q;

  lfsr_period_mon #(
    .WIDTH(WIDTH)
  ) u_period_mon (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed_val   (seed_fix),
    .advance    (advance),
    .next_state (next_state),
    .period_done(period_done),
    .period_len (period_len)
  );

endmodule

// File: tb/tb_lfsr_prng.sv
// tb/tb_lfsr_prng.sv - scoreboard bench for lfsr_prng in both Fibonacci and Galois form
module tb_lfsr_prng;

  localparam int W = 8;
  localparam int TAPS_F = 'h1D;
  localparam int MASK_G = 'hB8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic         out_ready = 1'b0;

  logic [W-1:0] data_f, data_g, plen_f, plen_g;
  logic         valid_f, valid_g, done_f, done_g;

  int errors = 0;
  int checks = 0;
  int popped = 0;
  int done_cnt_f = 0;
  int done_cnt_g = 0;
  logic [W-1:0] q_f[$];
  logic [W-1:0] q_g[$];
  logic [W-1:0] ms_f, ms_g;

  lfsr_prng #(.WIDTH(W), .MODE(0), .TAPS(32'h1D), .GMASK(32'hB8)) u_fib (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_data(data_f), .out_valid(valid_f), .out_ready(out_ready),
    .period_done(done_f), .period_len(plen_f)
  );

  lfsr_prng #(.WIDTH(W), .MODE(1), .TAPS(32'h1D), .GMASK(32'hB8)) u_gal (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_data(data_g), .out_valid(valid_g), .out_ready(out_ready),
    .period_done(done_g), .period_len(plen_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference step computed arithmetically: halve, then add parity feedback or fold in the mask.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input bit gal);
    int v, n, fb;
    v = int'(s);
    fb = 0;
    if (gal) begin
      n = (v / 2) ^ ((v % 2 == 1) ? MASK_G : 0);
    end else begin
      for (int i = 0; i < W; i++)
        if ((((TAPS_F >> i) & 1) == 1) && (((v >> i) & 1) == 1)) fb++;
      n = v / 2 + (fb % 2) * (1 << (W - 1));
    end
    if (n == 0) n = 1;
    return n[W-1:0];
  endfunction

  function automatic int model_period(input logic [W-1:0] seed, input bit gal);
    logic [W-1:0] s;
    int c;
    s = seed;
    c = 0;
    do begin
      s = model_next(s, gal);
      c++;
    end while (s != seed && c < (1 << W));
    return c;
  endfunction

  task automatic push_both(input int n);
    for (int i = 0; i < n; i++) begin
      q_f.push_back(ms_f);
      ms_f = model_next(ms_f, 1'b0);
      q_g.push_back(ms_g);
      ms_g = model_next(ms_g, 1'b1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_words(input int n);
    int target, guard;
    target = popped + n;
    guard = 0;
    en = 1'b1;
    while (popped < target && guard < 40 * n + 40) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    out_ready = 1'b0;
    if (popped < target) begin
      checks++;
      errors++;
      $display("FAIL run_words timeout: accepted %0d, required %0d", popped - (target - n), n);
    end
  endtask

  // Monitor: a handshake is pending whenever valid and ready are both high outside a load.
  always @(negedge clk) begin
    if (reset && !seed_load) begin
      if (valid_f && out_ready) begin
        if (q_f.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_fib unexpected: got %0h, required no word", data_f);
        end else begin
          check("word_fib", 32'(data_f), 32'(q_f.pop_front()));
        end
        popped++;
      end
      if (valid_g && out_ready) begin
        if (q_g.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_gal unexpected: got %0h, required no word", data_g);
        end else begin
          check("word_gal", 32'(data_g), 32'(q_g.pop_front()));
        end
      end
      if (done_f) done_cnt_f++;
      if (done_g) done_cnt_g++;
    end
  end

  initial begin
    logic [W-1:0] fib6 [6];
    logic [W-1:0] d0;
    int p0;
    fib6 = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};

    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    check("reset_data", 32'(data_f), 32'h01);
    check("reset_valid", 32'(valid_f), 32'h0);
    check("reset_done", 32'(done_f), 32'h0);
    check("reset_len", 32'(plen_f), 32'h0);
    check("reset_data_gal", 32'(data_g), 32'h01);

    // Fibonacci opening words are fixed constants; Galois comes from the model.
    ms_f = 8'h01;
    ms_g = 8'h01;
    for (int i = 0; i < 6; i++) begin
      q_f.push_back(fib6[i]);
      q_g.push_back(ms_g);
      ms_g = model_next(ms_g, 1'b1);
    end
    ms_f = model_next(8'h88, 1'b0);
    run_words(6);
    push_both(253);
    run_words(253);
    repeat (3) step();
    check("period_done_cnt_fib", 32'(done_cnt_f), 32'd1);
    check("period_len_fib", 32'(plen_f), 32'd255);
    check("period_done_cnt_gal", 32'(done_cnt_g), 32'd1);
    check("period_len_gal", 32'(plen_g), 32'(model_period(8'h01, 1'b1)));

    push_both(1);
    step();
    d0 = data_f;
    check("stall_front", 32'(d0), 32'(q_f[0]));
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_data", 32'(data_f), 32'(d0));
      check("stall_valid", 32'(valid_f), 32'h1);
    end
    en = 1'b0;
    step();
    check("stall_en_drop_valid", 32'(valid_f), 32'h1);
    p0 = popped;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("last_word_taken", 32'(popped - p0), 32'd1);
    check("valid_after_drop", 32'(valid_f), 32'h0);
    step();
    check("valid_stays_low", 32'(valid_f), 32'h0);

    q_f.delete();
    q_g.delete();
    seed_in = 8'h00;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("seed_zero_fib", 32'(data_f), 32'h01);
    check("seed_zero_gal", 32'(data_g), 32'h01);
    check("seed_zero_valid", 32'(valid_f), 32'h0);

    ms_f = 8'h01;
    ms_g = 8'h01;
    push_both(2);
    run_words(2);
    step();
    check("pre_load_valid", 32'(valid_f), 32'h1);
    out_ready = 1'b1;
    seed_in = 8'h5A;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    out_ready = 1'b0;
    check("seed_5a_fib", 32'(data_f), 32'h5A);
    check("seed_5a_gal", 32'(data_g), 32'h5A);
    check("seed_5a_valid_low", 32'(valid_f), 32'h0);
    step();
    check("seed_5a_valid_back", 32'(valid_f), 32'h1);
    check("seed_5a_hold", 32'(data_f), 32'h5A);

    done_cnt_f = 0;
    done_cnt_g = 0;
    ms_f = 8'h5A;
    ms_g = 8'h5A;
    push_both(256);
    run_words(256);
    repeat (3) step();
    check("seed_5a_done_fib", 32'(done_cnt_f), 32'd1);
    check("seed_5a_len_fib", 32'(plen_f), 32'(model_period(8'h5A, 1'b0)));
    check("seed_5a_done_gal", 32'(done_cnt_g), 32'd1);
    check("seed_5a_len_gal", 32'(plen_g), 32'(model_period(8'h5A, 1'b1)));

    step();
    check("pre_reset_valid", 32'(valid_f), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_data", 32'(data_f), 32'h01);
    check("async_reset_valid", 32'(valid_f), 32'h0);
    check("async_reset_len", 32'(plen_f), 32'h0);
    check("async_reset_len_gal", 32'(plen_g), 32'h0);
    q_f.delete();
    q_g.delete();
    step();
    reset = 1'b1;
    ms_f = 8'h01;
    ms_g = 8'h01;
    push_both(8);
    run_words(8);
    repeat (2) step();
    check("queue_drained_fib", 32'(q_f.size()), 32'd0);
    check("queue_drained_gal", 32'(q_g.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
